// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller.
// One shared full-adder cell (two half adders plus an OR) processes the
// operands LSB first, one bit per clock. The result, carry and signed
// overflow are registered on the final bit and held until the next operation
// completes.

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule

module serial_addsub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_reg;
   state_t             state_next;

   logic [WIDTH-1:0]   sa_reg;
   logic [WIDTH-1:0]   sb_reg;
   logic [WIDTH-1:0]   sr_reg;
   logic               c_reg;
   logic [CNT_W-1:0]   cnt_reg;

   logic [WIDTH-1:0]   sb_load;
   logic [WIDTH-1:0]   sr_shift;
   logic               ha0_s;
   logic               ha0_c;
   logic               ha1_c;
   logic               s_bit;
   logic               c_bit;
   logic               c_msb_in;
   logic               last_bit;

   // Subtraction is a + ~b + 1: invert B here, the +1 enters as the initial carry.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_sb_inv
         assign sb_load[gi] = b[gi] ^ op;
      end
   endgenerate

   // Shared 1-bit full-adder cell.
   half_adder u_ha0 (
      .x (sa_reg[0]),
      .y (sb_reg[0]),
      .s (ha0_s),
      .c (ha0_c)
   );

   half_adder u_ha1 (
      .x (ha0_s),
      .y (c_reg),
      .s (s_bit),
      .c (ha1_c)
   );

   assign c_bit    = ha0_c | ha1_c;
   assign sr_shift = {s_bit, sr_reg[WIDTH-1:1]};
   assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
   // While the final bit is being added, the carry register holds the carry into the MSB.
   assign c_msb_in = c_reg;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and Moore handshake outputs.
   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand load, serial shifting and result capture on the final bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_reg    <= '0;
         sb_reg    <= '0;
         sr_reg    <= '0;
         c_reg     <= 1'b0;
         cnt_reg   <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  sa_reg  <= a;
                  sb_reg  <= sb_load;
                  c_reg   <= op;
                  cnt_reg <= '0;
               end
            end
            RUN: begin
               sa_reg  <= sa_reg >> 1;
               sb_reg  <= sb_reg >> 1;
               c_reg   <= c_bit;
               sr_reg  <= sr_shift;
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (last_bit) begin
                  result    <= sr_shift;
                  carry_out <= c_bit;
                  overflow  <= c_msb_in ^ c_bit;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl (WIDTH=8).
// The driver pushes the expected response of each accepted operation; the
// monitor pops and compares whenever done is seen, and otherwise checks that
// the registered outputs hold their last completed value.

module tb_serial_addsub_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         o;
      int           e0;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         mon_e;
   logic [W-1:0] hold_res = '0;
   logic         hold_c   = 1'b0;
   logic         hold_o   = 1'b0;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  input logic xop, input int e0);
      exp_t e;
      int ua, ub, sa, sb, r, u;
      ua = int'(xa);
      ub = int'(xb);
      sa = int'($signed(xa));
      sb = int'($signed(xb));
      if (!xop) begin
         u   = ua + ub;
         e.c = (u > 255);
         r   = sa + sb;
      end else begin
         u   = ua - ub;
         e.c = (ua >= ub);
         r   = sa - sb;
      end
      e.res = W'(u & 255);
      e.o   = (r > 127) || (r < -128);
      e.e0  = e0;
      return e;
   endfunction

   // Monitor: compare on done, otherwise outputs must hold the last result.
   always @(negedge clk) begin
      if (rst) begin
         hold_res <= '0;
         hold_c   <= 1'b0;
         hold_o   <= 1'b0;
      end else begin
         chk("busy_done_excl", 32'(busy & done), 32'd0);
         if (done) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done got=done want=no_done t=%0t", $time);
            end else begin
               mon_e = sb_q.pop_front();
               chk("result", 32'(result), 32'(mon_e.res));
               chk("carry_out", 32'(carry_out), 32'(mon_e.c));
               chk("overflow", 32'(overflow), 32'(mon_e.o));
               chk("latency", 32'(cyc), 32'(mon_e.e0 + W));
               hold_res <= mon_e.res;
               hold_c   <= mon_e.c;
               hold_o   <= mon_e.o;
            end
         end else begin
            chk("hold_result", 32'(result), 32'(hold_res));
            chk("hold_carry", 32'(carry_out), 32'(hold_c));
            chk("hold_ovf", 32'(overflow), 32'(hold_o));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Present one start pulse; the accept edge is the next posedge.
   task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xop);
      tick();
      a     = xa;
      b     = xb;
      op    = xop;
      start = 1'b1;
      sb_q.push_back(model(xa, xb, xop, cyc + 1));
      tick();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      op    = 1'($urandom);
   endtask

   // Wait (bounded) for done; busy must be high on every cycle before it.
   task automatic wait_done();
      for (int n = 0; n < 40; n++) begin
         if (done) return;
         chk("busy_in_run", 32'(busy), 32'd1);
         tick();
      end
      checks++;
      errors++;
      $display("FAIL done_timeout got=no_done want=done t=%0t", $time);
   endtask

   task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xop, input int gap);
      issue(xa, xb, xop);
      wait_done();
      repeat (gap) tick();
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_carry", 32'(carry_out), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick();

      // Directed arithmetic cases
      do_op(8'h35, 8'h4A, 1'b0, 1);
      do_op(8'hFF, 8'h01, 1'b0, 0);
      do_op(8'h7F, 8'h01, 1'b0, 2);
      do_op(8'h05, 8'h07, 1'b1, 0);
      do_op(8'h80, 8'h01, 1'b1, 1);

      // start held through RUN and DONE: second op accepted right after DONE
      tick();
      a     = 8'h12;
      b     = 8'h34;
      op    = 1'b0;
      start = 1'b1;
      sb_q.push_back(model(8'h12, 8'h34, 1'b0, cyc + 1));
      tick();
      a  = 8'hA0;
      b  = 8'h0F;
      op = 1'b1;
      wait_done();
      sb_q.push_back(model(8'hA0, 8'h0F, 1'b1, cyc + 2));
      tick();
      chk("idle_after_done_busy", 32'(busy), 32'd0);
      chk("idle_after_done_done", 32'(done), 32'd0);
      tick();
      start = 1'b0;
      wait_done();
      tick();

      // Reset in the middle of a run
      do_op(8'hC3, 8'h11, 1'b0, 0);
      tick();
      a     = 8'h55;
      b     = 8'h22;
      op    = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", 32'(result), 32'd0);
      chk("midrst_carry", 32'(carry_out), 32'd0);
      chk("midrst_ovf", 32'(overflow), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("idle_after_rst", 32'(busy), 32'd0);
      end
      do_op(8'h10, 8'h20, 1'b0, 1);

      // Random operations with random idle gaps
      for (int i = 0; i < 1000; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      repeat (3) tick();
      chk("queue_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
